muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with its own HI/LO register pair, directly downstream of the general-purpose register file.
- Consumes busA/busB, the rs/rt operands read from the register file, for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Feeds HI/LO back toward the register-file write bus (busW) through rdata for MFHI/MFLO.
- Asserts busy so the pipeline control stalls dependent instructions while an iteration is in flight.

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand/result bundle between the pipeline control and the multiply/divide unit.
// Handshake: an op is taken at a rising edge where start=1 and busy=0; done pulses for one cycle when HI/LO change.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             rd_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       state_dbg;

  modport master (
    output start, op, busA, busB, rd_sel,
    input  busy, done, hi, lo, rdata, state_dbg
  );

  modport slave (
    input  start, op, busA, busB, rd_sel,
    output busy, done, hi, lo, rdata, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with its own HI/LO pair.
// Works on operand magnitudes and applies signs at the completion edge.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic               done_q;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_d;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic               last;

  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = op_signed & bus.busA[WIDTH-1];
  assign b_neg     = op_signed & bus.busB[WIDTH-1];
  assign a_mag     = a_neg ? ('0 - bus.busA) : bus.busA;
  assign b_mag     = b_neg ? ('0 - bus.busB) : bus.busB;

  // Multiply: upper half accumulates, lower half holds the multiplier being shifted out.
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_d   = {mul_sum, p_q[WIDTH-1:1]};
  assign mul_res = neg_res_q ? ('0 - mul_d) : mul_d;

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign div_shift = p_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_d     = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      p_q[WIDTH-2:0], div_ge};
  assign quo_res   = neg_res_q ? ('0 - div_d[WIDTH-1:0]) : div_d[WIDTH-1:0];
  assign rem_res   = neg_rem_q ? ('0 - div_d[2*WIDTH-1:WIDTH]) : div_d[2*WIDTH-1:WIDTH];

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                state_q   <= S_MUL;
                cnt_q     <= '0;
                p_q       <= {{WIDTH{1'b0}}, b_mag};
                opnd_q    <= a_mag;
                neg_res_q <= a_neg ^ b_neg;
              end
              OP_DIV, OP_DIVU: begin
                state_q   <= S_DIV;
                cnt_q     <= '0;
                p_q       <= {{WIDTH{1'b0}}, a_mag};
                opnd_q    <= b_mag;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                dz_q      <= (bus.busB == '0);
                dvd_q     <= bus.busA;
              end
              OP_MTHI: begin
                hi_q   <= bus.busA;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.busA;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          p_q   <= mul_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            {hi_q, lo_q} <= mul_res;
            done_q       <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_DIV: begin
          p_q   <= div_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            // A zero divisor still runs the full iteration; its result is fixed, not computed.
            if (dz_q) begin
              lo_q <= '1;
              hi_q <= dvd_q;
            end else begin
              lo_q <= quo_res;
              hi_q <= rem_res;
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.rdata     = bus.rd_sel ? hi_q : lo_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference {hi,lo} per op, monitor pops on done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] oh,
                                             input logic [W-1:0] ol);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq  = ua / ub;
          ur  = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      3'd4: res = {a, ol};
      3'd5: res = {oh, a};
      default: res = {oh, ol};
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("result_hilo", {bus.hi, bus.lo}, e);
        end
      end
    end
  end

  // Issues one op at a negedge and follows it to completion; returns just after a negedge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_k);
    logic [63:0]  e;
    logic [W-1:0] oh, ol;
    int           lat;
    bit           ok;
    bit           sel;
    oh  = m_hi;
    ol  = m_lo;
    lat = (op <= 3'd3) ? W : 0;
    e   = ref_result(op, a, b, oh, ol);
    if (op <= 3'd5) exp_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.busA  = a;
    bus.busB  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.busA  = $urandom;
    bus.busB  = $urandom;
    if (op > 3'd5) begin
      repeat (2) begin
        @(negedge clk);
        check("reserved_busy", 64'(bus.busy), 64'd0);
        check("reserved_done", 64'(bus.done), 64'd0);
      end
      check("reserved_hilo", {bus.hi, bus.lo}, {oh, ol});
      return;
    end
    ok = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== oh || bus.lo !== ol) ok = 1'b0;
      if (k == inj_k) begin
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.busA  = 32'h0000_1234;
      end
      if (k == inj_k + 1) bus.start = 1'b0;
    end
    if (lat > 0) check("busy_hold_window", 64'(ok), 64'd1);
    @(negedge clk);
    check("done_cycle_busy_done", {62'b0, bus.busy, bus.done}, 64'd1);
    {m_hi, m_lo} = e;
    sel        = 1'($urandom_range(0, 1));
    bus.rd_sel = sel;
    #1;
    check("rdata_mux", 64'(bus.rdata), 64'(sel ? m_hi : m_lo));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit no_done;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.busA   = '0;
    bus.busB   = '0;
    bus.rd_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd3, 32'd100, 32'd7, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'd5, 32'd0, 0);
    run_op(3'd1, 32'd1000, 32'd3000, 5);
    @(negedge clk);
    run_op(3'd4, 32'h0000_ABCD, 32'd0, 0);
    bus.rd_sel = 1'b1;
    #1;
    check("rdata_hi_same_cycle", 64'(bus.rdata), 64'h0000_ABCD);
    run_op(3'd6, 32'h5555_5555, 32'd9, 0);
    run_op(3'd7, 32'hAAAA_AAAA, 32'd9, 0);
    run_op(3'd5, 32'h0000_7777, 32'd0, 0);

    // Reset in the middle of an iteration discards the op
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.busA  = 32'hFFFF_FFFF;
    bus.busB  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop_reset_busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    check("no_done_after_reset", 64'(no_done), 64'd1);

    // Randomized ops, mixing back-to-back issue and idle gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
